apb_bridge_n: RTL

Parametrised APB3 master bridge: accepts single read/write requests from the processor side and runs them on an APB bus shared by `NUM_SLAVES` slaves. It handles address decode to per-slave `psel`, wait states via `pready`, error reporting via `pslverr`, and an optional access timeout. It replaces the fixed two-slave master/slave pairing as the bus front end between processor logic and memory-mapped peripherals.

---
 rtl/apb_bridge_n.sv | 187 ++++++++++++++++++
 1 files changed

// File: rtl/apb_bridge_n.sv
// apb_bridge_n: APB3 master bridge, one request in flight, NUM_SLAVES decode.
// Optional access timeout enabled by defining APB_TIMEOUT_EN.
module apb_bridge_n #(
    parameter int ADDR_W         = 32,
    parameter int DATA_W         = 32,
    parameter int NUM_SLAVES     = 4,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         req_valid,
    output logic                         req_ready,
    input  logic                         req_write,
    input  logic [ADDR_W-1:0]            req_addr,
    input  logic [DATA_W-1:0]            req_wdata,
    output logic                         rsp_valid,
    output logic [DATA_W-1:0]            rsp_rdata,
    output logic                         rsp_err,
    output logic [NUM_SLAVES-1:0]        psel,
    output logic                         penable,
    output logic                         pwrite,
    output logic [ADDR_W-1:0]            paddr,
    output logic [DATA_W-1:0]            pwdata,
    input  logic [NUM_SLAVES*DATA_W-1:0] prdata,
    input  logic [NUM_SLAVES-1:0]        pready,
    input  logic [NUM_SLAVES-1:0]        pslverr
);

    localparam int SEL_W = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        ACCESS,
        RESP
    } state_t;

    state_t                 state, state_n;
    logic [SEL_W-1:0]       idx, idx_n;
    logic [NUM_SLAVES-1:0]  psel_n;
    logic                   penable_n;
    logic                   pwrite_n;
    logic [ADDR_W-1:0]      paddr_n;
    logic [DATA_W-1:0]      pwdata_n;
    logic                   rsp_valid_n;
    logic                   rsp_err_n;
    logic [DATA_W-1:0]      rsp_rdata_n;

    logic [SEL_W-1:0]       req_idx;
    logic                   req_miss;
    logic [NUM_SLAVES-1:0]  req_onehot;
    logic                   sel_ready;
    logic                   sel_err;
    logic [DATA_W-1:0]      sel_rdata;
    logic                   timeout;

    assign req_idx   = req_addr[ADDR_W-1 -: SEL_W];
    assign req_miss  = ({1'b0, req_idx} >= (SEL_W+1)'(NUM_SLAVES));
    assign req_ready = (state == IDLE);

    // One-hot select for the incoming request and mux of the latched slave
    always_comb begin
        req_onehot = '0;
        sel_ready  = 1'b0;
        sel_err    = 1'b0;
        sel_rdata  = '0;
        for (int i = 0; i < NUM_SLAVES; i++) begin
            req_onehot[i] = (req_idx == SEL_W'(i));
            if (idx == SEL_W'(i)) begin
                sel_ready = pready[i];
                sel_err   = pslverr[i];
                sel_rdata = prdata[i*DATA_W +: DATA_W];
            end
        end
    end

`ifdef APB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [CNT_W-1:0] cnt;

    // ACCESS cycle number, 1 on the first ACCESS cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (state == SETUP) begin
            cnt <= CNT_W'(1);
        end else if (state == ACCESS) begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    assign timeout = (cnt == CNT_W'(TIMEOUT_CYCLES));
`else
    assign timeout = 1'b0;
`endif

    // Next state and next values of every registered output
    always_comb begin
        state_n     = state;
        idx_n       = idx;
        psel_n      = psel;
        penable_n   = penable;
        pwrite_n    = pwrite;
        paddr_n     = paddr;
        pwdata_n    = pwdata;
        rsp_valid_n = 1'b0;
        rsp_err_n   = rsp_err;
        rsp_rdata_n = rsp_rdata;
        unique case (state)
            IDLE: begin
                if (req_valid) begin
                    idx_n    = req_idx;
                    paddr_n  = req_addr;
                    pwrite_n = req_write;
                    pwdata_n = req_wdata;
                    if (req_miss) begin
                        state_n     = RESP;
                        rsp_valid_n = 1'b1;
                        rsp_err_n   = 1'b1;
                        rsp_rdata_n = '0;
                    end else begin
                        state_n = SETUP;
                        psel_n  = req_onehot;
                    end
                end
            end
            SETUP: begin
                state_n   = ACCESS;
                penable_n = 1'b1;
            end
            ACCESS: begin
                if (sel_ready) begin
                    state_n     = RESP;
                    psel_n      = '0;
                    penable_n   = 1'b0;
                    rsp_valid_n = 1'b1;
                    rsp_err_n   = sel_err;
                    rsp_rdata_n = (!pwrite && !sel_err) ? sel_rdata : '0;
                end else if (timeout) begin
                    state_n     = RESP;
                    psel_n      = '0;
                    penable_n   = 1'b0;
                    rsp_valid_n = 1'b1;
                    rsp_err_n   = 1'b1;
                    rsp_rdata_n = '0;
                end
            end
            RESP: begin
                state_n = IDLE;
            end
            default: begin
                state_n   = IDLE;
                psel_n    = '0;
                penable_n = 1'b0;
            end
        endcase
    end

    // State and output registers; reset abandons any transfer at once
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            idx       <= '0;
            psel      <= '0;
            penable   <= 1'b0;
            pwrite    <= 1'b0;
            paddr     <= '0;
            pwdata    <= '0;
            rsp_valid <= 1'b0;
            rsp_err   <= 1'b0;
            rsp_rdata <= '0;
        end else begin
            state     <= state_n;
            idx       <= idx_n;
            psel      <= psel_n;
            penable   <= penable_n;
            pwrite    <= pwrite_n;
            paddr     <= paddr_n;
            pwdata    <= pwdata_n;
            rsp_valid <= rsp_valid_n;
            rsp_err   <= rsp_err_n;
            rsp_rdata <= rsp_rdata_n;
        end
    end

endmodule
